// File: rtl/fallthrough_fifo_v3_pkg.sv
// Shared helpers and constants for the fallthrough FIFO v3.
package fallthrough_fifo_v3_pkg;

  // Bit positions of the sticky error flags inside the packed error vector.
  localparam int unsigned ErrOverflowBit  = 0;
  localparam int unsigned ErrUnderflowBit = 1;
  localparam int unsigned ErrBits         = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/fallthrough_fifo_v3_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module fifo_ram_sdp #(
  parameter int unsigned WIDTH     = 72,
  parameter int unsigned ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fallthrough_fifo_v3.sv
// First-word-fall-through FIFO: RAM -> ram_q stage -> middle stage -> dout register,
// with occupancy counters, programmable thresholds, flush and sticky error flags.
module fallthrough_fifo_v3
  import fallthrough_fifo_v3_pkg::*;
#(
  parameter int unsigned WIDTH                = 72,
  parameter int unsigned MAX_DEPTH_BITS       = 3,
  parameter int unsigned PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS - 1,
  parameter int unsigned PROG_EMPTY_THRESHOLD = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic                      flush,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          dout,
  output logic                      empty,
  output logic                      full,
  output logic                      nearly_full,
  output logic                      prog_full,
  output logic                      prog_empty,
  output logic [MAX_DEPTH_BITS+1:0] data_count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned DEPTH  = 2**MAX_DEPTH_BITS;
  localparam int unsigned RcBits = clog2(DEPTH + 1);
  localparam int unsigned DcBits = MAX_DEPTH_BITS + 2;

  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RcBits-1:0]         ram_count_q, ram_count_d;
  logic [DcBits-1:0]         data_count_q, data_count_d;
  logic                      ramq_valid_q, ramq_valid_d;
  logic                      middle_valid_q, middle_valid_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      full_q, nearly_full_q, prog_full_q, prog_empty_q;
  logic [ErrBits-1:0]        err_q, err_d;
  logic [WIDTH-1:0]          middle_q, dout_q, ram_rd_data;
  logic                      wr_acc, rd_acc, ram_rd, update_dout, update_middle;

  // Handshake decode; flush masks every other request for the cycle.
  always_comb begin
    wr_acc        = wr_en & ~full_q & ~flush;
    rd_acc        = rd_en & dout_valid_q & ~flush;
    update_dout   = (middle_valid_q | ramq_valid_q) & (rd_en | ~dout_valid_q) & ~flush;
    update_middle = ramq_valid_q & (middle_valid_q == update_dout) & ~flush;
    ram_rd        = (ram_count_q != '0) & ~(ramq_valid_q & middle_valid_q & dout_valid_q)
                    & ~flush;
  end

  fifo_ram_sdp #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (MAX_DEPTH_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // Next-state for pointers, counters, stage valids and error flags.
  always_comb begin
    wr_ptr_d       = wr_ptr_q + MAX_DEPTH_BITS'(wr_acc);
    rd_ptr_d       = rd_ptr_q + MAX_DEPTH_BITS'(ram_rd);
    ram_count_d    = ram_count_q + RcBits'(wr_acc) - RcBits'(ram_rd);
    data_count_d   = data_count_q + DcBits'(wr_acc) - DcBits'(rd_acc);
    ramq_valid_d   = ramq_valid_q;
    middle_valid_d = middle_valid_q;
    dout_valid_d   = dout_valid_q;
    if (flush) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      ram_count_d    = '0;
      data_count_d   = '0;
      ramq_valid_d   = 1'b0;
      middle_valid_d = 1'b0;
      dout_valid_d   = 1'b0;
    end else begin
      if (update_dout) begin
        dout_valid_d = 1'b1;
      end else if (rd_en) begin
        dout_valid_d = 1'b0;
      end
      if (update_middle) begin
        middle_valid_d = 1'b1;
      end else if (update_dout && middle_valid_q) begin
        middle_valid_d = 1'b0;
      end
      // ram_q empties when its word moves on, unless a fresh RAM read refills it.
      if (ram_rd) begin
        ramq_valid_d = 1'b1;
      end else if (update_middle || (update_dout && !middle_valid_q)) begin
        ramq_valid_d = 1'b0;
      end
    end
    // A new error event wins over clr_err in the same cycle.
    err_d = clr_err ? '0 : err_q;
    if (wr_en && full_q && !flush) begin
      err_d[ErrOverflowBit] = 1'b1;
    end
    if (rd_en && !dout_valid_q && !flush) begin
      err_d[ErrUnderflowBit] = 1'b1;
    end
  end

  // Control state; flags are registered from the next-state counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ram_count_q    <= '0;
      data_count_q   <= '0;
      ramq_valid_q   <= 1'b0;
      middle_valid_q <= 1'b0;
      dout_valid_q   <= 1'b0;
      full_q         <= 1'b0;
      nearly_full_q  <= 1'b0;
      prog_full_q    <= 1'b0;
      prog_empty_q   <= 1'b1;
      err_q          <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ram_count_q    <= ram_count_d;
      data_count_q   <= data_count_d;
      ramq_valid_q   <= ramq_valid_d;
      middle_valid_q <= middle_valid_d;
      dout_valid_q   <= dout_valid_d;
      full_q         <= (ram_count_d == RcBits'(DEPTH));
      nearly_full_q  <= (ram_count_d >= RcBits'(DEPTH - 1));
      prog_full_q    <= (ram_count_d >= RcBits'(PROG_FULL_THRESHOLD));
      prog_empty_q   <= (data_count_d <= DcBits'(PROG_EMPTY_THRESHOLD));
      err_q          <= err_d;
    end
  end

  // Output-stage data; dout holds its value through a flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      middle_q <= '0;
      dout_q   <= '0;
    end else begin
      if (update_middle) begin
        middle_q <= ram_rd_data;
      end
      if (update_dout) begin
        dout_q <= middle_valid_q ? middle_q : ram_rd_data;
      end
    end
  end

  assign dout        = dout_q;
  assign empty       = ~dout_valid_q;
  assign full        = full_q;
  assign nearly_full = nearly_full_q;
  assign prog_full   = prog_full_q;
  assign prog_empty  = prog_empty_q;
  assign data_count  = data_count_q;
  assign overflow    = err_q[ErrOverflowBit];
  assign underflow   = err_q[ErrUnderflowBit];

endmodule

// File: doc/fallthrough_fifo_v3.md
Name: fallthrough_fifo_v3

Overview:
Parametrised first-word-fall-through FIFO. It succeeds the v2 fallthrough FIFO and has its own storage, so it no longer wraps small_fifo_v3. Compared with v2 it adds:
- occupancy count
- programmable full/empty thresholds
- synchronous flush
- sticky overflow/underflow error flags
- asynchronous active-low reset

It is used wherever the datapath needs registered-output FWFT buffering, such as packet-generator header/payload queues.

Parameters:
WIDTH, 72, data width in bits.
MAX_DEPTH_BITS, 3, log2 of RAM depth (DEPTH = 2**MAX_DEPTH_BITS).
PROG_FULL_THRESHOLD, 2**MAX_DEPTH_BITS-1, prog_full asserts when ram_count >= this value.
PROG_EMPTY_THRESHOLD, 1, prog_empty asserts when data_count <= this value.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
din  in  WIDTH  write data.
wr_en  in  1  write request.
rd_en  in  1  read/pop of the current dout word.
flush  in  1  synchronous clear of all contents.
clr_err  in  1  clears overflow and underflow.
dout  out  WIDTH  head word; valid whenever empty=0.
empty  out  1  no valid word on dout.
full  out  1  RAM occupancy == DEPTH.
nearly_full  out  1  RAM occupancy >= DEPTH-1.
prog_full  out  1  RAM occupancy >= PROG_FULL_THRESHOLD.
prog_empty  out  1  data_count <= PROG_EMPTY_THRESHOLD.
data_count  out  MAX_DEPTH_BITS+2  total words held (RAM + 3 output stages); maximum DEPTH+3.
overflow  out  1  sticky; set on a dropped write.
underflow  out  1  sticky; set on a read while empty.

Behaviour:
- Reset (reset_n=0, async assert, sync release):
  - write and read pointers = 0; ram_count = 0; data_count = 0.
  - stage valid flags (ram_q, middle, dout) = 0; dout = 0.
  - empty=1, full=0, nearly_full=0, prog_full=0, prog_empty=1, overflow=0, underflow=0.
- Storage: simple dual-port RAM, registered read. Pipeline order is RAM -> ram_q stage -> middle stage -> dout register.
- Stage rules:
  - update_dout = (middle_valid | ramq_valid) & (rd_en | !dout_valid).
  - update_middle = ramq_valid & (middle_valid == update_dout).
  - ram_rd = ram_count != 0 & !(ramq_valid & middle_valid & dout_valid).
- Latency: a word written at edge k into an empty FIFO gives dout = that word and empty=0 after edge k+2.
- Throughput: simultaneous rd_en and wr_en in steady state sustains 1 word/cycle with no bubbles.
- Write accepted iff wr_en & !full & !flush. wr_en with full=1 is dropped and sets overflow. This holds even if a read frees space in the same cycle (full is registered).
- Read accepted iff rd_en & !empty & !flush. rd_en with empty=1 is ignored and sets underflow.
- Counts:
  - ram_count: +1 on accepted write, -1 on ram_rd; both in one cycle leaves it unchanged.
  - data_count: +1 on accepted write, -1 on accepted read.
  - All flags are registered from the next-state counts, so they are valid in the cycle after the event.
- Pointers wrap modulo DEPTH; occupancy comes from the counters, not from pointer comparison.
- flush:
  - next edge: pointers, counts and all valid flags go to 0; empty=1; dout retains its value.
  - flush has priority over wr_en and rd_en in the same cycle; those are ignored and do not set error flags.
- clr_err clears both sticky flags; a new error event in the same cycle wins (flag stays 1).
- Ordering is strict FIFO across wrap, flush recovery and back-pressure.

Decomposition:
- Shared package/header: CLOG2 function; error-flag bit indices, if the flags are later packed into a status register.
- One sub-module: fifo_ram_sdp (WIDTH, ADDR_BITS; write port plus registered read port; no reset on array contents).
- Control, counters and output stages live in fallthrough_fifo_v3.

Test Plan (WIDTH=16, MAX_DEPTH_BITS=3, PROG_FULL_THRESHOLD=6, PROG_EMPTY_THRESHOLD=1):
1. Release reset, write 0xA5A5 at edge 0 -> empty=0 and dout=0xA5A5 after edge 2, data_count=1; pulse rd_en -> empty=1, data_count=0, underflow=0.
2. Write 0x0001..0x000C back-to-back, no reads:
   - after 11 writes: full=1, data_count=11.
   - 12th write dropped; overflow=1.
   - read 11 -> dout sequence 0x0001..0x000B; 12th rd_en sets underflow=1.
   - clr_err -> both flags 0.
3. Pre-fill 4 words, then 100 cycles of simultaneous wr_en and rd_en -> one word out per cycle, in order; data_count stays 4; empty never asserts.
4. Fill 5 words, assert flush together with wr_en and rd_en -> next cycle empty=1, data_count=0, prog_empty=1, no error flags; write 0x0BEE -> dout=0x0BEE after 2 edges.
5. Drop reset_n asynchronously between edges with 6 words held -> all outputs take reset values immediately; after release, writing then reading 0x1234 works.
6. Push 0x0000..0x0017 (3xDEPTH) with random rd_en/wr_en gaps -> output matches input order exactly across pointer wrap; prog_full tracks ram_count >= 6 at every cycle.
